// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Valid/ready request and result ports let the EX stage stall until the result is accepted.
module div_unit #(
  parameter  int Oprand_Width = 32,
  localparam int Cnt_Width    = $clog2(Oprand_Width) + 1
) (
  input  logic                    i_CLK,
  input  logic                    i_RST_N,
  input  logic                    i_Flush,
  input  logic                    i_Req_Valid,
  output logic                    o_Req_Ready,
  input  logic [1:0]              i_DIV_OP,
  input  logic [Oprand_Width-1:0] i_SrcA_E,
  input  logic [Oprand_Width-1:0] i_SrcB_E,
  output logic                    o_Res_Valid,
  input  logic                    i_Res_Ready,
  output logic [Oprand_Width-1:0] o_Res_E,
  output logic                    o_Busy
);

  localparam logic [Oprand_Width-1:0] MinNeg = {1'b1, {(Oprand_Width-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [Cnt_Width-1:0]    cnt_q;
  logic [Oprand_Width-1:0] quo_q;
  logic [Oprand_Width-1:0] rem_q;
  logic [Oprand_Width-1:0] dvsr_q;
  logic                    is_rem_q;
  logic                    neg_q_q;
  logic                    neg_r_q;
  logic                    valid_q;
  logic [Oprand_Width-1:0] res_q;

  // Request decode: bit 0 selects unsigned, bit 1 selects remainder.
  logic                    accept;
  logic                    signed_op;
  logic                    sign_a;
  logic                    sign_b;
  logic [Oprand_Width-1:0] mag_a;
  logic [Oprand_Width-1:0] mag_b;
  logic                    div_zero;
  logic                    overflow;
  logic                    special;

  assign accept    = i_Req_Valid && (state == IDLE) && !i_Flush;
  assign signed_op = ~i_DIV_OP[0];
  assign sign_a    = signed_op & i_SrcA_E[Oprand_Width-1];
  assign sign_b    = signed_op & i_SrcB_E[Oprand_Width-1];
  assign mag_a     = sign_a ? -i_SrcA_E : i_SrcA_E;
  assign mag_b     = sign_b ? -i_SrcB_E : i_SrcB_E;
  assign div_zero  = (i_SrcB_E == '0);
  assign overflow  = signed_op && (i_SrcA_E == MinNeg) && (i_SrcB_E == '1);
  assign special   = div_zero || overflow;

  // One restoring step; the shifted remainder is one bit wider so the compare cannot wrap.
  logic [Oprand_Width:0]   rem_shift;
  logic [Oprand_Width:0]   rem_diff;
  logic                    take;
  logic [Oprand_Width-1:0] rem_nxt;
  logic [Oprand_Width-1:0] quo_nxt;

  assign rem_shift = {rem_q, quo_q[Oprand_Width-1]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};
  assign take      = (rem_shift >= {1'b0, dvsr_q});
  assign rem_nxt   = Oprand_Width'(take ? rem_diff : rem_shift);
  assign quo_nxt   = {quo_q[Oprand_Width-2:0], take};

  logic [Oprand_Width-1:0] quo_fin;
  logic [Oprand_Width-1:0] rem_fin;

  assign quo_fin = neg_q_q ? -quo_q : quo_q;
  assign rem_fin = neg_r_q ? -rem_q : rem_q;

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets its default before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (cnt_q == Cnt_Width'(1)) state_nxt = DONE;
      DONE: if (valid_q && i_Res_Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_Flush) state_nxt = IDLE;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      valid_q  <= 1'b0;
      res_q    <= '0;
    end else if (i_Flush) begin
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            is_rem_q <= i_DIV_OP[1];
            dvsr_q   <= mag_b;
            cnt_q    <= Cnt_Width'(Oprand_Width);
            if (div_zero) begin
              // Architectural results, already in final form: no sign fix-up.
              quo_q   <= '1;
              rem_q   <= i_SrcA_E;
              neg_q_q <= 1'b0;
              neg_r_q <= 1'b0;
            end else if (overflow) begin
              quo_q   <= MinNeg;
              rem_q   <= '0;
              neg_q_q <= 1'b0;
              neg_r_q <= 1'b0;
            end else begin
              quo_q   <= mag_a;
              rem_q   <= '0;
              neg_q_q <= sign_a ^ sign_b;
              neg_r_q <= sign_a;
            end
          end
        end
        CALC: begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q - Cnt_Width'(1);
        end
        DONE: begin
          // First DONE cycle applies signs and registers the result; it is then held.
          if (!valid_q) begin
            valid_q <= 1'b1;
            res_q   <= is_rem_q ? rem_fin : quo_fin;
          end else if (i_Res_Ready) begin
            valid_q <= 1'b0;
          end
        end
        default: valid_q <= 1'b0;
      endcase
    end
  end

  assign o_Req_Ready = (state == IDLE);
  assign o_Res_Valid = valid_q;
  assign o_Res_E     = res_q;
  assign o_Busy      = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic vectors with hand-computed results and latencies,
// special cases, result backpressure, flush and asynchronous reset.
module tb_div_unit;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .i_CLK       (clk),
    .i_RST_N     (rst_n),
    .i_Flush     (flush),
    .i_Req_Valid (req_valid),
    .o_Req_Ready (req_ready),
    .i_DIV_OP    (op),
    .i_SrcA_E    (src_a),
    .i_SrcB_E    (src_b),
    .o_Res_Valid (res_valid),
    .i_Res_Ready (res_ready),
    .o_Res_E     (res),
    .o_Busy      (busy)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expect_res;
    int          expect_lat;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{"divu_100_7",      OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{"remu_100_7",      OP_REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{"remu_ffff_16",    OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          33};
    vecs[3]  = '{"div_m7_2",        OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[4]  = '{"rem_m7_2",        OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[5]  = '{"rem_7_m2",        OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[6]  = '{"div_7_m2",        OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[7]  = '{"div_min_2",       OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  33};
    vecs[8]  = '{"div_5_0",         OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[9]  = '{"divu_5_0",        OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[10] = '{"rem_x_0",         OP_REM,  32'h8000_0001,  32'd0,          32'h8000_0001,  1};
    vecs[11] = '{"remu_x_0",        OP_REMU, 32'h8000_0001,  32'd0,          32'h8000_0001,  1};
    vecs[12] = '{"div_ovf",         OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[13] = '{"rem_ovf",         OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[14] = '{"divu_ovf_ops",    OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, scrambles the inputs after accept, and waits (bounded) for the result.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat);
    int waits = 0;
    while (!req_ready && waits < 100) begin
      tick();
      waits++;
    end
    req_valid = 1'b1;
    op        = o;
    src_a     = a;
    src_b     = b;
    tick();
    req_valid = 1'b0;
    op        = ~o;
    src_a     = ~a;
    src_b     = b + 32'd3;
    lat       = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (res_valid) begin
        lat = i;
        break;
      end
    end
    r = res;
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({req_ready, res_valid, busy, res} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b valid=%b busy=%b res=%h want 1 0 0 0",
               req_ready, res_valid, busy, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_vectors(input int lo, input int hi);
    logic [31:0] r;
    int          lat;
    for (int i = lo; i <= hi; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
      n_checks++;
      if (lat !== vecs[i].expect_lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", vecs[i].name, lat, vecs[i].expect_lat);
      end
      n_checks++;
      if (r !== vecs[i].expect_res) begin
        n_fail++;
        $display("FAIL %s result: got %h want %h", vecs[i].name, r, vecs[i].expect_res);
      end
      release_res();
      n_checks++;
      if ({res_valid, req_ready, busy} !== 3'b010) begin
        n_fail++;
        $display("FAIL %s release: got valid=%b ready=%b busy=%b want 0 1 0",
                 vecs[i].name, res_valid, req_ready, busy);
      end
    end
  endtask

  task automatic test_unsigned();
    run_vectors(0, 2);
  endtask

  task automatic test_signed();
    run_vectors(3, 7);
  endtask

  task automatic test_special();
    run_vectors(8, 14);
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    int          lat;
    do_op(OP_DIVU, 32'd100, 32'd7, r, lat);
    n_checks++;
    if (lat !== 33 || r !== 32'd14) begin
      n_fail++;
      $display("FAIL bp_first: got lat=%0d res=%h want 33 0000000e", lat, r);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({res_valid, req_ready, busy, res} !== {1'b1, 1'b0, 1'b1, 32'd14}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b busy=%b res=%h want 1 0 1 0000000e",
                 i, res_valid, req_ready, busy, res);
      end
    end
    release_res();
    n_checks++;
    if ({res_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b ready=%b want 0 1", res_valid, req_ready);
    end
  endtask

  task automatic test_flush();
    logic [31:0] r;
    int          lat;
    req_valid = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
    tick();
    req_valid = 1'b0;
    repeat (16) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if ({busy, res_valid, req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL flush_calc: got busy=%b valid=%b ready=%b want 0 0 1", busy, res_valid, req_ready);
    end
    repeat (40) tick();
    n_checks++;
    if ({busy, res_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_discard: got busy=%b valid=%b want 0 0", busy, res_valid);
    end
    // Flush together with a request in IDLE drops the request.
    req_valid = 1'b1; flush = 1'b1; op = OP_DIVU; src_a = 32'd9; src_b = 32'd0;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({busy, res_valid, req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL flush_with_req: got busy=%b valid=%b ready=%b want 0 0 1", busy, res_valid, req_ready);
    end
    // Flush in DONE discards a pending result.
    do_op(OP_DIVU, 32'd5, 32'd0, r, lat);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if ({busy, res_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_done: got busy=%b valid=%b want 0 0", busy, res_valid);
    end
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, r, lat);
    n_checks++;
    if (r !== 32'hFFFF_FFFF || lat !== 33) begin
      n_fail++;
      $display("FAIL flush_fresh: got res=%h lat=%0d want ffffffff 33", r, lat);
    end
    release_res();
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    int          lat;
    req_valid = 1'b1; op = OP_DIVU; src_a = 32'd12345; src_b = 32'd17;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, res_valid, req_ready, res} !== {1'b0, 1'b0, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b valid=%b ready=%b res=%h want 0 0 1 0",
               busy, res_valid, req_ready, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, r, lat);
    n_checks++;
    if (r !== 32'hFFFF_FFFF || lat !== 33) begin
      n_fail++;
      $display("FAIL reset_fresh: got res=%h lat=%0d want ffffffff 33", r, lat);
    end
    release_res();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
